// File: rtl/nanov_serial_regfile_pkg.sv
// Shared configuration helpers for the nanoV digit-serial register file.
package nanov_pkg;

  localparam int ZERO_REG = 0;

  function automatic bit digit_legal(input int digit);
    return (digit == 1) || (digit == 2) || (digit == 4) || (digit == 8);
  endfunction

  function automatic int calc_ndig(input int xlen, input int digit);
    return xlen / digit;
  endfunction

  function automatic int calc_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

  // Index counters keep at least one bit even when a word is a single digit.
  function automatic int calc_iw(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

endpackage

// File: rtl/nanov_serial_regfile_reg.sv
// One rotating XLEN-bit register; its low digit is always the current architectural digit.
// NANOV_REGFILE_DEBUG_EN exposes the raw (still rotated) register contents.
module nanov_serial_reg #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr,
  input  logic [DIGIT-1:0] rd_data,
  output logic [DIGIT-1:0] low_digit
`ifdef NANOV_REGFILE_DEBUG_EN
  ,
  output logic [XLEN-1:0]  word
`endif
);

  logic [XLEN-1:0]  q;
  logic [DIGIT-1:0] top_digit;

  // A write replaces the digit that is leaving the bottom on this rotation.
  assign top_digit = wr ? rd_data : q[DIGIT-1:0];
  assign low_digit = q[DIGIT-1:0];

  generate
    if (XLEN == DIGIT) begin : g_single
      always_ff @(posedge clk) begin
        if (!rstn) q <= '0;
        else       q <= top_digit;
      end
    end else begin : g_rotate
      always_ff @(posedge clk) begin
        if (!rstn) q <= '0;
        else       q <= {top_digit, q[XLEN-1:DIGIT]};
      end
    end
  endgenerate

`ifdef NANOV_REGFILE_DEBUG_EN
  assign word = q;
`endif

endmodule

// File: rtl/nanov_serial_regfile.sv
// Digit-serial register file: NREGS-1 rotating registers stepped by a shared digit counter.
// Optional debug word port enabled by defining NANOV_REGFILE_DEBUG_EN.
module nanov_serial_regfile
  import nanov_pkg::*;
#(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 16,
  parameter  int DIGIT = 1,
  localparam int AW    = calc_aw(NREGS),
  localparam int NDIG  = calc_ndig(XLEN, DIGIT),
  localparam int IW    = calc_iw(NDIG)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic             read_through,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic [AW-1:0]    rd,
  input  logic [DIGIT-1:0] rd_data,
  output logic [DIGIT-1:0] rs1_data,
  output logic [DIGIT-1:0] rs2_data,
  output logic [IW-1:0]    digit_idx,
  output logic             word_start
`ifdef NANOV_REGFILE_DEBUG_EN
  ,
  input  logic [AW-1:0]    dbg_sel,
  output logic [XLEN-1:0]  dbg_word
`endif
);

  generate
    if (!digit_legal(DIGIT) || (XLEN % DIGIT) != 0 || NREGS < 2 || NREGS > 32 ||
        (NREGS & (NREGS - 1)) != 0) begin : g_bad_cfg
      $error("nanov_serial_regfile: illegal XLEN/NREGS/DIGIT combination");
    end
  endgenerate

  logic [IW-1:0]    idx_q;
  logic [DIGIT-1:0] low [NREGS];
  logic             bypass1;
  logic             bypass2;

  generate
    if (NDIG == 1) begin : g_no_cnt
      assign idx_q = '0;
    end else begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rstn)                        idx_q <= '0;
        else if (idx_q == IW'(NDIG - 1))  idx_q <= '0;
        else                              idx_q <= idx_q + 1'b1;
      end
    end
  endgenerate

  assign digit_idx  = idx_q;
  assign word_start = (idx_q == '0);

`ifdef NANOV_REGFILE_DEBUG_EN
  logic [XLEN-1:0]   words [NREGS];
  logic [XLEN-1:0]   dbg_raw;
  logic [2*XLEN-1:0] dbg_dbl;

  assign words[0] = '0;
`endif

  // Register 0 is never instantiated, so writes to it vanish and reads see zero.
  assign low[0] = '0;

  generate
    for (genvar i = 1; i < NREGS; i++) begin : g_regs
      nanov_serial_reg #(
        .XLEN  (XLEN),
        .DIGIT (DIGIT)
      ) u_reg (
        .clk       (clk),
        .rstn      (rstn),
        .wr        (wr_en && (rd == AW'(i))),
        .rd_data   (rd_data),
        .low_digit (low[i])
`ifdef NANOV_REGFILE_DEBUG_EN
        ,
        .word      (words[i])
`endif
      );
    end
  endgenerate

  assign bypass1 = wr_en && read_through && (rd != AW'(ZERO_REG)) && (rs1 == rd);
  assign bypass2 = wr_en && read_through && (rd != AW'(ZERO_REG)) && (rs2 == rd);

  always_comb begin
    rs1_data = low[rs1];
    rs2_data = low[rs2];
    if (bypass1) rs1_data = rd_data;
    if (bypass2) rs2_data = rd_data;
  end

`ifdef NANOV_REGFILE_DEBUG_EN
  // Physical contents are the architectural word rotated right by digit_idx digits.
  assign dbg_raw  = words[dbg_sel];
  assign dbg_dbl  = {dbg_raw, dbg_raw} << (int'(idx_q) * DIGIT);
  assign dbg_word = dbg_dbl[2*XLEN-1:XLEN];
`endif

endmodule

// File: tb/tb_nanov_serial_regfile.sv
// Scoreboard bench for nanov_serial_regfile (XLEN=32, NREGS=16, DIGIT=4) against a word-level model.
module tb_nanov_serial_regfile;

  localparam int XLEN  = 32;
  localparam int NREGS = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = XLEN / DIGIT;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr_en;
  logic             read_through;
  logic [3:0]       rs1;
  logic [3:0]       rs2;
  logic [3:0]       rd;
  logic [DIGIT-1:0] rd_data;
  logic [DIGIT-1:0] rs1_data;
  logic [DIGIT-1:0] rs2_data;
  logic [2:0]       digit_idx;
  logic             word_start;
  logic [3:0]       dbg_sel;
`ifdef NANOV_REGFILE_DEBUG_EN
  logic [XLEN-1:0]  dbg_word;
`endif

  always #5 clk = ~clk;

  nanov_serial_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .DIGIT (DIGIT)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .wr_en        (wr_en),
    .read_through (read_through),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .rd_data      (rd_data),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .digit_idx    (digit_idx),
    .word_start   (word_start)
`ifdef NANOV_REGFILE_DEBUG_EN
    ,
    .dbg_sel      (dbg_sel),
    .dbg_word     (dbg_word)
`endif
  );

  typedef struct {
    logic [DIGIT-1:0] rs1;
    logic [DIGIT-1:0] rs2;
    logic [2:0]       idx;
    logic             ws;
    logic [XLEN-1:0]  dbg;
  } exp_t;

  exp_t            sb_q[$];
  logic [XLEN-1:0] mem [NREGS];
  int              cnt;
  bit              model_valid;
  int              n_checks;
  int              n_fail;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Architectural read of one port: bypass first, otherwise digit cnt of the stored word.
  function automatic logic [DIGIT-1:0] model_read(input logic [3:0] a, input bit w,
                                                  input bit rt, input logic [3:0] d,
                                                  input logic [DIGIT-1:0] data);
    logic [XLEN-1:0] v;
    if (w && rt && d != 0 && a == d) return data;
    v = mem[a] >> (cnt * DIGIT);
    return v[DIGIT-1:0];
  endfunction

  task automatic applyStimulus(input bit rst_n, input bit w, input bit rt,
                               input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] d, input logic [DIGIT-1:0] data,
                               input logic [3:0] ds);
    exp_t e;
    rstn = rst_n; wr_en = w; read_through = rt;
    rs1 = a1; rs2 = a2; rd = d; rd_data = data; dbg_sel = ds;
    if (model_valid) begin
      e.rs1 = model_read(a1, w, rt, d, data);
      e.rs2 = model_read(a2, w, rt, d, data);
      e.idx = 3'(cnt);
      e.ws  = (cnt == 0);
      e.dbg = mem[ds];
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] = '0;
      cnt = 0;
      model_valid = 1'b1;
    end else begin
      if (w && d != 0) mem[d][cnt*DIGIT +: DIGIT] = data;
      cnt = (cnt + 1) % NDIG;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [3:0] a1, input logic [3:0] a2,
                      input logic [3:0] ds);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, a1, a2, 4'd0, '0, ds);
  endtask

  task automatic align_word();
    while (cnt != 0) idle(1, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic write_word(input logic [3:0] r, input logic [XLEN-1:0] val, input bit rt,
                            input logic [3:0] a1, input logic [3:0] a2, input int ndigits);
    align_word();
    for (int k = 0; k < NDIG; k++)
      applyStimulus(1'b1, k < ndigits, rt, a1, a2, r, val[k*DIGIT +: DIGIT], r);
  endtask

  // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("rs1_data", 32'(rs1_data), 32'(e.rs1));
        checkOutput("rs2_data", 32'(rs2_data), 32'(e.rs2));
        checkOutput("digit_idx", 32'(digit_idx), 32'(e.idx));
        checkOutput("word_start", 32'(word_start), 32'(e.ws));
`ifdef NANOV_REGFILE_DEBUG_EN
        checkOutput("dbg_word", dbg_word, e.dbg);
`endif
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    cnt = 0;
    model_valid = 1'b0;
    for (int i = 0; i < NREGS; i++) mem[i] = '0;

    $display("[TB] reset and idle read");
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, '0, 4'd0);
    idle(2 * NDIG, 4'd5, 4'd0, 4'd5);

    $display("[TB] full write without and with read-through");
    write_word(4'd3, 32'hDEADBEEF, 1'b0, 4'd3, 4'd1, NDIG);
    idle(NDIG, 4'd1, 4'd3, 4'd3);
    write_word(4'd3, 32'h01234567, 1'b1, 4'd3, 4'd3, NDIG);
    idle(NDIG, 4'd3, 4'd3, 4'd3);

    $display("[TB] x0 write and partial write");
    write_word(4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd0, NDIG);
    idle(NDIG, 4'd0, 4'd0, 4'd0);
    write_word(4'd7, 32'h0000005A, 1'b0, 4'd7, 4'd3, 2);
    idle(NDIG, 4'd7, 4'd7, 4'd7);

    $display("[TB] reset mid-word");
    align_word();
    for (int k = 0; k < 4; k++)
      applyStimulus(1'b1, 1'b1, 1'b0, 4'd2, 4'd3, 4'd2, 4'(32'h12345678 >> (k * 4)), 4'd2);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd2, 4'd3, 4'd2, 4'h3, 4'd2);
    idle(NDIG, 4'd2, 4'd3, 4'd2);

    $display("[TB] debug word");
    write_word(4'd9, 32'hCAFEF00D, 1'b0, 4'd9, 4'd0, NDIG);
    idle(NDIG, 4'd9, 4'd9, 4'd9);

    $display("[TB] random traffic");
    for (int k = 0; k < 600; k++)
      applyStimulus($urandom_range(0, 99) != 0, 1'($urandom), 1'($urandom),
                    4'($urandom), 4'($urandom), 4'($urandom_range(0, 5)),
                    4'($urandom), 4'($urandom));
    idle(NDIG, 4'd1, 4'd2, 4'd3);

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
